// File: rtl/cb_filter_pkg.sv
// Shared types for the counting bloom filter family: hash seeds,
// example seed set and the drain state machine encoding.
package cb_filter_pkg;

    // One seed pair per hash function: rotation amount and xor mask.
    typedef struct packed {
        int unsigned PermuteSeed;
        int unsigned XorSeed;
    } cb_seed_t;

    localparam cb_seed_t [2:0] EgSeeds = '{
        '{PermuteSeed: 32'd299034753, XorSeed: 32'd4094834},
        '{PermuteSeed: 32'd19921030,  XorSeed: 32'd995713},
        '{PermuteSeed: 32'd294388,    XorSeed: 32'd65146511}
    };

    // Drain state machine: normal operation, draining, drained.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } cbf_state_e;

endpackage

// File: rtl/cb_filter_mport_if.sv
// Lookup, insert and remove channels of cb_filter_mport.
// master drives data/valid, slave (the filter) returns hits/ready.
interface cb_filter_mport_if #(
    parameter int unsigned NoLookPorts = 2,
    parameter int unsigned InpWidth    = 32
);
    logic [NoLookPorts-1:0][InpWidth-1:0] look_data_i;
    logic [NoLookPorts-1:0]               look_valid_o;
    logic [InpWidth-1:0]                  incr_data_i;
    logic                                 incr_valid_i;
    logic                                 incr_ready_o;
    logic [InpWidth-1:0]                  decr_data_i;
    logic                                 decr_valid_i;
    logic                                 decr_ready_o;

    modport master (
        output look_data_i, incr_data_i, incr_valid_i, decr_data_i, decr_valid_i,
        input  look_valid_o, incr_ready_o, decr_ready_o
    );

    modport slave (
        input  look_data_i, incr_data_i, incr_valid_i, decr_data_i, decr_valid_i,
        output look_valid_o, incr_ready_o, decr_ready_o
    );
endinterface

// File: rtl/cbf_sat_bucket.sv
// One saturating bucket counter. Simultaneous up and down cancel, an
// all-ones count is frozen until clear, and a down on zero is flagged.
module cbf_sat_bucket #(
    parameter int unsigned Width = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic up_i,
    input  logic dn_i,
    output logic sat_o,
    output logic zero_o,
    output logic underflow_o
);

    logic [Width-1:0] r_cnt;
    logic             w_sat;
    logic             w_zero;

    assign w_sat  = &r_cnt;
    assign w_zero = (r_cnt == '0);

    // Count with saturation at all-ones and floor at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (up_i && !dn_i && !w_sat) begin
            r_cnt <= r_cnt + Width'(1);
        end else if (dn_i && !up_i && !w_sat && !w_zero) begin
            r_cnt <= r_cnt - Width'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign sat_o       = w_sat;
    assign zero_o      = w_zero;
    assign underflow_o = dn_i & ~up_i & w_zero;

endmodule

// File: rtl/hash_block.sv
// Maps a data word to a bucket indicator vector: each of NoHashes hashes
// runs NoRounds of xor/rotate/mix, then xor-folds to a bucket index.
module hash_block
    import cb_filter_pkg::*;
#(
    parameter int unsigned NoHashes  = 3,
    parameter int unsigned InpWidth  = 32,
    parameter int unsigned HashWidth = 4,
    parameter int unsigned NoRounds  = 1,
    parameter cb_seed_t [NoHashes-1:0] Seeds = EgSeeds
) (
    input  logic [InpWidth-1:0]       data_i,
    output logic [2**HashWidth-1:0]   indicator_o
);

    // Hash the input once per seed and mark each selected bucket
    always_comb begin
        logic [InpWidth-1:0]  w_x;
        logic [InpWidth-1:0]  w_y;
        logic [HashWidth-1:0] w_idx;
        indicator_o = '0;
        w_x         = '0;
        w_y         = '0;
        w_idx       = '0;
        for (int unsigned h = 0; h < NoHashes; h++) begin
            w_x = data_i;
            for (int unsigned r = 0; r < NoRounds; r++) begin
                w_x = w_x ^ InpWidth'(Seeds[h].XorSeed);
                w_y = '0;
                for (int unsigned b = 0; b < InpWidth; b++) begin
                    w_y[(b + Seeds[h].PermuteSeed + r) % InpWidth] = w_x[b];
                end
                w_x = w_y ^ (w_y >> (InpWidth / 32'd2)) ^ (w_y << 32'd3);
            end
            w_idx = '0;
            for (int unsigned b = 0; b < InpWidth; b++) begin
                w_idx[b % HashWidth] = w_idx[b % HashWidth] ^ w_x[b];
            end
            indicator_o[w_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cb_filter_mport.sv
// Counting bloom filter with NoLookPorts parallel lookups, valid/ready
// insert/remove, capacity-limited item counter and a drain FSM.
// Optional macro CB_FILTER_LOOK_REG_EN registers the lookup results
// (latency 1); by default lookups are combinational (latency 0).
module cb_filter_mport
    import cb_filter_pkg::*;
#(
    parameter int unsigned KHashes     = 3,
    parameter int unsigned HashWidth   = 4,
    parameter int unsigned HashRounds  = 1,
    parameter int unsigned InpWidth    = 32,
    parameter int unsigned BucketWidth = 4,
    parameter int unsigned NoLookPorts = 2,
    parameter int unsigned UsageWidth  = 8,
    parameter int unsigned Capacity    = 16,
    parameter cb_seed_t [KHashes-1:0] Seeds = EgSeeds
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cb_filter_mport_if.slave      bus,
    input  logic                  clear_i,
    input  logic                  drain_i,
    output logic                  drain_done_o,
    output logic [UsageWidth-1:0] usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  sat_o,
    output logic                  error_o
);

    localparam int unsigned NoBuckets = 2 ** HashWidth;

    logic [NoBuckets-1:0]                  w_incr_ind;
    logic [NoBuckets-1:0]                  w_decr_ind;
    logic [NoLookPorts-1:0][NoBuckets-1:0] w_look_ind;
    logic [NoLookPorts-1:0]                w_look_hit;
    logic [NoBuckets-1:0]                  w_bsat;
    logic [NoBuckets-1:0]                  w_bzero;
    logic [NoBuckets-1:0]                  w_bunder;

    logic [UsageWidth-1:0] r_usage;
    logic                  r_error;
    cbf_state_e            r_state;

    logic w_full;
    logic w_incr_ready;
    logic w_decr_ready;
    logic w_incr_fire;
    logic w_decr_fire;
    logic w_usage_under;

    assign w_full        = (r_usage == UsageWidth'(Capacity));
    assign w_incr_ready  = !clear_i && (r_state == RUN) && !w_full;
    assign w_decr_ready  = !clear_i;
    assign w_incr_fire   = bus.incr_valid_i & w_incr_ready;
    assign w_decr_fire   = bus.decr_valid_i & w_decr_ready;
    assign w_usage_under = w_decr_fire & ~w_incr_fire & (r_usage == '0);

    hash_block #(
        .NoHashes (KHashes),
        .InpWidth (InpWidth),
        .HashWidth(HashWidth),
        .NoRounds (HashRounds),
        .Seeds    (Seeds)
    ) u_hash_incr (
        .data_i     (bus.incr_data_i),
        .indicator_o(w_incr_ind)
    );

    hash_block #(
        .NoHashes (KHashes),
        .InpWidth (InpWidth),
        .HashWidth(HashWidth),
        .NoRounds (HashRounds),
        .Seeds    (Seeds)
    ) u_hash_decr (
        .data_i     (bus.decr_data_i),
        .indicator_o(w_decr_ind)
    );

    for (genvar p = 0; p < NoLookPorts; p++) begin : g_look
        hash_block #(
            .NoHashes (KHashes),
            .InpWidth (InpWidth),
            .HashWidth(HashWidth),
            .NoRounds (HashRounds),
            .Seeds    (Seeds)
        ) u_hash_look (
            .data_i     (bus.look_data_i[p]),
            .indicator_o(w_look_ind[p])
        );
        // A hit needs every selected bucket to be nonzero (pre-update state)
        assign w_look_hit[p] = &(~w_look_ind[p] | ~w_bzero);
    end

    for (genvar i = 0; i < NoBuckets; i++) begin : g_bucket
        cbf_sat_bucket #(
            .Width(BucketWidth)
        ) u_bucket (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .up_i       (w_incr_fire & w_incr_ind[i]),
            .dn_i       (w_decr_fire & w_decr_ind[i]),
            .sat_o      (w_bsat[i]),
            .zero_o     (w_bzero[i]),
            .underflow_o(w_bunder[i])
        );
    end

    // Item counter: +1 on insert, -1 on remove, hold when both or at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_usage <= '0;
        end else if (clear_i) begin
            r_usage <= '0;
        end else if (w_incr_fire && !w_decr_fire) begin
            r_usage <= r_usage + UsageWidth'(1);
        end else if (w_decr_fire && !w_incr_fire && (r_usage != '0)) begin
            r_usage <= r_usage - UsageWidth'(1);
        end else begin
            r_usage <= r_usage;
        end
    end

    // Sticky error on any bucket or item-counter underflow
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_error <= 1'b0;
        end else if (clear_i) begin
            r_error <= 1'b0;
        end else if ((|w_bunder) || w_usage_under) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    // Drain FSM; the empty test uses the registered item count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RUN;
        end else if (clear_i) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (drain_i) begin
                        r_state <= (r_usage != '0) ? DRAIN : DONE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (!drain_i) begin
                        r_state <= RUN;
                    end else if (r_usage == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    if (!drain_i) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef CB_FILTER_LOOK_REG_EN
    logic [NoLookPorts-1:0] r_look_valid;

    // Registered lookup results, one cycle behind the lookup data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_look_valid <= '0;
        end else if (clear_i) begin
            r_look_valid <= '0;
        end else begin
            r_look_valid <= w_look_hit;
        end
    end

    assign bus.look_valid_o = r_look_valid;
`else
    assign bus.look_valid_o = w_look_hit;
`endif

    assign bus.incr_ready_o = w_incr_ready;
    assign bus.decr_ready_o = w_decr_ready;
    assign drain_done_o     = (r_state == DONE);
    assign usage_o          = r_usage;
    assign full_o           = w_full;
    assign empty_o          = &w_bzero;
    assign sat_o            = |w_bsat;
    assign error_o          = r_error;

endmodule

// File: tb/tb_cb_filter_mport.sv
// Self-checking bench for cb_filter_mport: vector table for the basic
// insert/remove/lookup cases, loops for fill, saturation and drain.
module tb_cb_filter_mport;

    localparam int NLP = 2;
    localparam int IW  = 32;
    localparam int UW  = 8;
    localparam int CAP = 16;

    localparam logic [1:0] XX = 2'b00;  // not checked
    localparam logic [1:0] E0 = 2'b10;  // expect 0
    localparam logic [1:0] E1 = 2'b11;  // expect 1

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] VA = 32'h0BADF00D;
    localparam logic [31:0] VC = 32'hC0FFEE00;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        dv;
        logic [31:0] dd;
        logic        clr;
        logic        drn;
        logic [31:0] l0;
        logic [31:0] l1;
        logic [1:0]  look;
        logic [1:0]  lmask;
        logic [1:0]  empty;
        logic [1:0]  sat;
    } vec_t;

    typedef struct {
        logic       ri;
        logic       rd;
        int         usage;
        logic       full;
        logic       done;
        logic       err;
        logic [1:0] look;
        logic [1:0] lmask;
        logic [1:0] empty;
        logic [1:0] sat;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          drain_i;
    logic          drain_done_o;
    logic [UW-1:0] usage_o;
    logic          full_o;
    logic          empty_o;
    logic          sat_o;
    logic          error_o;

    int nerr = 0;
    int nchk = 0;

    // bench reference state: 0 RUN, 1 DRAIN, 2 DONE
    int   m_usage;
    int   m_st;
    logic m_err;

    exp_t sb[$];
    vec_t tbl[10];

    cb_filter_mport_if #(.NoLookPorts(NLP), .InpWidth(IW)) bus ();

    cb_filter_mport #(
        .NoLookPorts(NLP),
        .InpWidth   (IW),
        .UsageWidth (UW),
        .Capacity   (CAP)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .clear_i     (clear_i),
        .drain_i     (drain_i),
        .drain_done_o(drain_done_o),
        .usage_o     (usage_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .sat_o       (sat_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic dv,
                                input logic [31:0] dd, input logic clr, input logic drn,
                                input logic [31:0] l0, input logic [31:0] l1,
                                input logic [1:0] look, input logic [1:0] lmask,
                                input logic [1:0] empty, input logic [1:0] sat);
        vec_t v;
        v.iv = iv; v.id = id; v.dv = dv; v.dd = dd; v.clr = clr; v.drn = drn;
        v.l0 = l0; v.l1 = l1; v.look = look; v.lmask = lmask; v.empty = empty; v.sat = sat;
        return v;
    endfunction

    // drive one cycle, push expectation, pop and compare, advance reference
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        logic fi;
        logic fd;
        int   nst;
        @(negedge clk_i);
        bus.incr_valid_i   = v.iv;
        bus.incr_data_i    = v.id;
        bus.decr_valid_i   = v.dv;
        bus.decr_data_i    = v.dd;
        bus.look_data_i[0] = v.l0;
        bus.look_data_i[1] = v.l1;
        clear_i            = v.clr;
        drain_i            = v.drn;

        e.ri    = !v.clr && (m_st == 0) && (m_usage != CAP);
        e.rd    = !v.clr;
        e.usage = m_usage;
        e.full  = (m_usage == CAP);
        e.done  = (m_st == 2);
        e.err   = m_err;
        e.look  = v.look;
        e.lmask = v.lmask;
        e.empty = v.empty;
        e.sat   = v.sat;
        sb.push_back(e);

        #2;
        g = sb.pop_front();
        check("incr_ready", 32'(bus.incr_ready_o), 32'(g.ri));
        check("decr_ready", 32'(bus.decr_ready_o), 32'(g.rd));
        check("usage", 32'(usage_o), 32'(g.usage));
        check("full", 32'(full_o), 32'(g.full));
        check("drain_done", 32'(drain_done_o), 32'(g.done));
        check("error", 32'(error_o), 32'(g.err));
        for (int p = 0; p < NLP; p++) begin
            if (g.lmask[p]) check($sformatf("look_valid[%0d]", p), 32'(bus.look_valid_o[p]), 32'(g.look[p]));
        end
        if (g.empty[1]) check("empty", 32'(empty_o), 32'(g.empty[0]));
        if (g.sat[1]) check("sat", 32'(sat_o), 32'(g.sat[0]));

        fi = v.iv && e.ri;
        fd = v.dv && e.rd;
        if (v.clr) begin
            m_usage = 0;
            m_err   = 1'b0;
            m_st    = 0;
        end else begin
            nst = m_st;
            case (m_st)
                0: if (v.drn) nst = (m_usage != 0) ? 1 : 2;
                1: if (!v.drn) nst = 0; else if (m_usage == 0) nst = 2;
                2: if (!v.drn) nst = 0;
                default: nst = 0;
            endcase
            m_st = nst;
            if (fi && !fd) m_usage = m_usage + 1;
            else if (fd && !fi) begin
                if (m_usage == 0) m_err = 1'b1;
                else m_usage = m_usage - 1;
            end
        end
    endtask

    task automatic idle(input logic drn, input logic [31:0] l0, input logic [1:0] look,
                        input logic [1:0] lmask, input logic [1:0] empty, input logic [1:0] sat);
        apply(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, drn, l0, l0, look, lmask, empty, sat));
    endtask

    task automatic ins(input logic [31:0] d, input logic drn, input logic [1:0] sat);
        apply(mk(1'b1, d, 1'b0, 32'h0, 1'b0, drn, d, d, 2'b00, 2'b00, XX, sat));
    endtask

    task automatic rem(input logic [31:0] d, input logic drn);
        apply(mk(1'b0, 32'h0, 1'b1, d, 1'b0, drn, d, d, 2'b00, 2'b00, XX, XX));
    endtask

    task automatic clr(input logic drn);
        apply(mk(1'b1, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1, drn, 32'h0, 32'h0, 2'b00, 2'b00, XX, XX));
    endtask

    initial begin
        rst_ni           = 1'b0;
        clear_i          = 1'b0;
        drain_i          = 1'b0;
        bus.incr_valid_i = 1'b0;
        bus.incr_data_i  = '0;
        bus.decr_valid_i = 1'b0;
        bus.decr_data_i  = '0;
        bus.look_data_i  = '0;
        m_usage          = 0;
        m_st             = 0;
        m_err            = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // reset state, insert/remove DEADBEEF, same-cycle insert+remove
        tbl[0] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, DB, VA, 2'b00, 2'b11, E1, E0);
        tbl[1] = mk(1'b1, DB,    1'b0, 32'h0, 1'b0, 1'b0, DB, DB, 2'b00, 2'b11, E1, E0);
        tbl[2] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, DB, DB, 2'b11, 2'b11, E0, E0);
        tbl[3] = mk(1'b0, 32'h0, 1'b1, DB,    1'b0, 1'b0, DB, DB, 2'b11, 2'b11, E0, E0);
        tbl[4] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, DB, VA, 2'b00, 2'b11, E1, E0);
        tbl[5] = mk(1'b1, VA,    1'b0, 32'h0, 1'b0, 1'b0, VA, VA, 2'b00, 2'b00, XX, XX);
        tbl[6] = mk(1'b1, VA,    1'b1, VA,    1'b0, 1'b0, VA, VA, 2'b11, 2'b11, E0, E0);
        tbl[7] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, VA, VA, 2'b11, 2'b11, E0, E0);
        tbl[8] = mk(1'b0, 32'h0, 1'b1, VA,    1'b0, 1'b0, VA, VA, 2'b00, 2'b00, XX, XX);
        tbl[9] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, DB, VA, 2'b00, 2'b11, E1, E0);
        for (int i = 0; i < 10; i++) apply(tbl[i]);

        // fill to capacity, a 17th insert is refused, then clear
        for (int i = 0; i < CAP; i++) ins(32'h13570000 + 32'(i) * 32'h00010F01, 1'b0, XX);
        ins(32'hFFFF0000, 1'b0, XX);
        idle(1'b0, 32'h0, 2'b00, 2'b00, E0, XX);
        clr(1'b0);
        idle(1'b0, DB, 2'b00, 2'b11, E1, E0);

        // saturate one value's buckets, then over-remove
        for (int i = 0; i < 15; i++) ins(VC, 1'b0, E0);
        idle(1'b0, VC, 2'b11, 2'b11, E0, E1);
        for (int i = 0; i < 20; i++) rem(VC, 1'b0);
        idle(1'b0, VC, 2'b11, 2'b11, E0, E1);
        clr(1'b0);
        idle(1'b0, VC, 2'b00, 2'b11, E1, E0);

        // drain with 3 items, inserts blocked, completes after removes
        for (int i = 0; i < 3; i++) ins(32'hB0000001 + 32'(i), 1'b0, XX);
        idle(1'b1, 32'h0, 2'b00, 2'b00, E0, XX);
        ins(32'hB0000010, 1'b1, XX);
        for (int i = 0; i < 3; i++) rem(32'hB0000001 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, DB, 2'b00, 2'b11, E1, E0);
        idle(1'b0, DB, 2'b00, 2'b11, E1, E0);
        idle(1'b0, DB, 2'b00, 2'b11, E1, E0);

        // clear in the middle of a drain
        ins(32'hB0000020, 1'b0, XX);
        ins(32'hB0000021, 1'b0, XX);
        idle(1'b1, 32'h0, 2'b00, 2'b00, E0, XX);
        rem(32'hB0000020, 1'b1);
        clr(1'b1);
        idle(1'b0, 32'hB0000021, 2'b00, 2'b11, E1, E0);
        ins(32'hB0000030, 1'b0, XX);
        idle(1'b0, 32'hB0000030, 2'b11, 2'b11, E0, E0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
